// File: rtl/spi_pkg.sv
// SPI controller shared types and mode constants.
// Imported by spi_sck_gen and spi_ctrl_master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_TX,
    ST_PAUSE,
    ST_RX,
    ST_TRAIL,
    ST_GAP
  } spi_ctrl_state_t;

  // Mode 0: SCK idles low, data sampled on rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  // Counter width for a 0..n-1 counter, never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider: CLK_DIV clk cycles per half-period.
// Held low while disabled; rise/fall ticks flag the edge about to occur.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] hcnt;
  logic          wrap;

  assign wrap = en && (hcnt == HALF_LAST);
  assign rise = wrap && !sck;
  assign fall = wrap && sck;

  // Half-period counter; toggles SCK at each wrap, restarts low on disable.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      hcnt <= '0;
      sck  <= 1'b0;
    end else if (wrap) begin
      hcnt <= '0;
      sck  <= ~sck;
    end else begin
      hcnt <= hcnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_ctrl_master.sv
// SPI mode-0 controller: one CS-low window holds TX, PAUSE and RX phases.
// FSM and shift registers live here; SCK timing comes from spi_sck_gen.
module spi_ctrl_master
  import spi_pkg::*;
#(
  parameter int unsigned LENGTH_SEND_C     = 16,
  parameter int unsigned LENGTH_RECIEVED_C = 16,
  parameter int unsigned LENGTH_COUNT_C    = 6,
  parameter int unsigned PAUSE             = 10,
  parameter int unsigned CLK_DIV           = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LENGTH_SEND_C-1:0]     tx_data,
  output logic                         busy,
  output logic                         done,
  output logic [LENGTH_RECIEVED_C-1:0] rx_data,
  output logic                         SCK,
  output logic                         CS,
  output logic                         COPI,
  input  logic                         CIPO
);

  localparam int unsigned CW = cnt_w(CLK_DIV);
  localparam int unsigned PW = cnt_w(PAUSE);
  localparam int unsigned LC = LENGTH_COUNT_C;

  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PAUSE_LAST =
    PW'((PAUSE > 0) ? (PAUSE - 1) : 0);
  localparam logic [LC-1:0] TX_LAST = LC'(LENGTH_SEND_C - 1);
  localparam logic [LC-1:0] RX_LAST = LC'(LENGTH_RECIEVED_C - 1);

  spi_ctrl_state_t state;

  logic [LENGTH_SEND_C-1:0]     tx_sh;
  logic [LENGTH_RECIEVED_C-1:0] rx_sh;
  logic [LC-1:0]                bit_cnt;
  logic [CW-1:0]                cnt;
  logic [PW-1:0]                pcnt;

  logic sck_en;
  logic sck_lvl;
  logic sck_rise;
  logic sck_fall;
  logic shift_tick;
  logic sample_tick;

  assign sck_en = (state == ST_TX) || (state == ST_RX);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk (clk),
    .rst (rst),
    .en  (sck_en),
    .sck (sck_lvl),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  assign SCK         = sck_lvl ^ SPI_CPOL;
  assign shift_tick  = SPI_CPHA ? sck_rise : sck_fall;
  assign sample_tick = SPI_CPHA ? sck_fall : sck_rise;

  // Frame sequencer; every output is a register so CS/COPI never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      CS      <= 1'b1;
      COPI    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
      pcnt    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            tx_sh <= tx_data;
            COPI  <= tx_data[LENGTH_SEND_C-1];
            CS    <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= ST_TX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_TX: begin
          if (shift_tick) begin
            if (bit_cnt == TX_LAST) begin
              COPI    <= 1'b0;
              bit_cnt <= '0;
              pcnt    <= '0;
              state   <= (PAUSE == 0) ? ST_RX : ST_PAUSE;
            end else begin
              bit_cnt <= bit_cnt + LC'(1);
              tx_sh   <= tx_sh << 1;
              COPI    <= tx_sh[LENGTH_SEND_C-2];
            end
          end
        end
        ST_PAUSE: begin
          if (pcnt == PAUSE_LAST) begin
            state <= ST_RX;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        ST_RX: begin
          if (sample_tick) begin
            rx_sh <= {rx_sh[LENGTH_RECIEVED_C-2:0], CIPO};
          end
          if (shift_tick) begin
            if (bit_cnt == RX_LAST) begin
              cnt   <= '0;
              state <= ST_TRAIL;
            end else begin
              bit_cnt <= bit_cnt + LC'(1);
            end
          end
        end
        ST_TRAIL: begin
          if (cnt == HALF_LAST) begin
            CS      <= 1'b1;
            done    <= 1'b1;
            rx_data <= rx_sh;
            cnt     <= '0;
            state   <= ST_GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt == HALF_LAST) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ctrl_master.sv
// Scoreboard bench for spi_ctrl_master with an SCK-edge peripheral model.
// Side 0: CLK_DIV=2, PAUSE=10. Side 1: CLK_DIV=1, PAUSE=0.
module tb_spi_ctrl_master;

  typedef struct {
    logic [15:0] tx;
    logic [15:0] rx;
    int          len;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        rst   [2];
  logic        start [2];
  logic        busy  [2];
  logic        done  [2];
  logic        sck   [2];
  logic        cs    [2];
  logic        copi  [2];
  logic        cipo  [2];
  logic [15:0] tx_d  [2];
  logic [15:0] rxd   [2];

  exp_t        sb_q   [2][$];
  logic [15:0] resp_q [2][$];

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    ntests++;
    nfail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  spi_ctrl_master #(
    .LENGTH_SEND_C(16), .LENGTH_RECIEVED_C(16), .LENGTH_COUNT_C(6),
    .PAUSE(10), .CLK_DIV(2)
  ) dut_a (
    .clk(clk), .rst(rst[0]), .start(start[0]), .tx_data(tx_d[0]),
    .busy(busy[0]), .done(done[0]), .rx_data(rxd[0]),
    .SCK(sck[0]), .CS(cs[0]), .COPI(copi[0]), .CIPO(cipo[0])
  );

  spi_ctrl_master #(
    .LENGTH_SEND_C(16), .LENGTH_RECIEVED_C(16), .LENGTH_COUNT_C(6),
    .PAUSE(0), .CLK_DIV(1)
  ) dut_b (
    .clk(clk), .rst(rst[1]), .start(start[1]), .tx_data(tx_d[1]),
    .busy(busy[1]), .done(done[1]), .rx_data(rxd[1]),
    .SCK(sck[1]), .CS(cs[1]), .COPI(copi[1]), .CIPO(cipo[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_side
    localparam int CD = (g == 0) ? 2 : 1;
    localparam int PS = (g == 0) ? 10 : 0;

    int          rise_n = 0;
    int          fall_n = 0;
    logic [15:0] cap = '0;
    logic [15:0] resp_cur = '0;
    logic        pcs_m = 1'b1;
    logic        psck_m = 1'b0;

    assign cipo[g] = (fall_n >= 16 && fall_n < 32) ?
                     resp_cur[4'(31 - fall_n)] : 1'b0;

    // Peripheral: captures COPI on SCK rise, shifts CIPO on SCK fall.
    always @(cs[g] or sck[g]) begin
      if (pcs_m === 1'b1 && cs[g] === 1'b0) begin
        rise_n = 0;
        fall_n = 0;
        cap    = '0;
        if (resp_q[g].size() > 0) resp_cur = resp_q[g].pop_front();
        else resp_cur = 16'h0;
      end
      if (psck_m !== 1'b1 && sck[g] === 1'b1) begin
        if (rise_n < 16) cap = {cap[14:0], copi[g]};
        rise_n++;
      end
      if (psck_m === 1'b1 && sck[g] === 1'b0) fall_n++;
      pcs_m  = cs[g];
      psck_m = sck[g];
    end

    int   lowcnt = 0;
    int   nrise = 0;
    int   lastrise = 0;
    int   badper = 0;
    int   viol_copi = 0;
    int   viol_idle = 0;
    int   viol_done = 0;
    logic prev_sck = 1'b0;
    logic prev_copi = 1'b0;
    logic prev_done = 1'b0;
    exp_t e;

    // Monitor: invariants every cycle, scoreboard pop on each done.
    always @(negedge clk) begin
      if (prev_sck === 1'b1 && sck[g] === 1'b1 && copi[g] !== prev_copi)
        viol_copi++;
      if (cs[g] === 1'b1 && sck[g] === 1'b1) viol_idle++;
      if (done[g] === 1'b1 && prev_done === 1'b1) viol_done++;
      if (sck[g] === 1'b1 && prev_sck !== 1'b1) begin
        if (nrise > 0 &&
            cyc - lastrise != 2 * CD + ((nrise == 16) ? PS : 0))
          badper++;
        lastrise = cyc;
        nrise++;
      end
      if (cs[g] === 1'b0) begin
        lowcnt++;
      end else begin
        if (done[g] === 1'b1) begin
          if (sb_q[g].size() == 0) begin
            fail_now($sformatf("side%0d_unexpected_done", g));
          end else begin
            e = sb_q[g].pop_front();
            check($sformatf("side%0d_rx_data", g), rxd[g], e.rx);
            check($sformatf("side%0d_periph_cap", g), cap, e.tx);
            check($sformatf("side%0d_cs_low_len", g), lowcnt, e.len);
            check($sformatf("side%0d_sck_rises", g), nrise, 32);
            check($sformatf("side%0d_sck_period", g), badper, 0);
          end
        end
        lowcnt = 0;
        nrise  = 0;
        badper = 0;
      end
      prev_sck  = sck[g];
      prev_copi = copi[g];
      prev_done = done[g];
    end
  end

  function automatic int exp_len(input int g);
    return (g == 0) ? 142 : 66;
  endfunction

  task automatic send(input int g, input logic [15:0] tx,
                      input logic [15:0] rx, input bit expect_done);
    resp_q[g].push_back(rx);
    if (expect_done) sb_q[g].push_back(exp_t'{tx, rx, exp_len(g)});
    start[g] = 1'b1;
    tx_d[g]  = tx;
    @(negedge clk);
    start[g] = 1'b0;
    tx_d[g]  = ~tx;
  endtask

  task automatic wait_done(input int g, input int budget, input string name);
    int n = 0;
    while (done[g] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done[g] !== 1'b1) fail_now({name, "_done"});
  endtask

  task automatic wait_idle(input int g, input int budget, input string name);
    int n = 0;
    while (busy[g] !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy[g] !== 1'b0) fail_now({name, "_idle"});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int drop;
    int gap;

    for (int g = 0; g < 2; g++) begin
      rst[g]   = 1'b1;
      start[g] = 1'b0;
      tx_d[g]  = 16'h0;
    end
    repeat (4) @(negedge clk);
    check("rst_cs", cs[0], 1);
    check("rst_sck", sck[0], 0);
    check("rst_copi", copi[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_rx_data", rxd[0], 0);
    check("rst_cs_b", cs[1], 1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    // 1: single frame; tx_data changes after accept are ignored
    send(0, 16'hA5C3, 16'h3C5A, 1'b1);
    wait_done(0, 400, "t1");
    wait_idle(0, 20, "t1");

    // 2: start held for the whole frame gives exactly one frame
    resp_q[0].push_back(16'hABCD);
    sb_q[0].push_back(exp_t'{16'h1234, 16'hABCD, 142});
    start[0] = 1'b1;
    tx_d[0]  = 16'h1234;
    @(negedge clk);
    drop = 0;
    n    = 0;
    while (done[0] !== 1'b1 && n < 400) begin
      if (busy[0] !== 1'b1) drop++;
      @(negedge clk);
      n++;
    end
    start[0] = 1'b0;
    if (done[0] !== 1'b1) fail_now("t2_done");
    check("t2_busy_held", drop, 0);
    wait_idle(0, 20, "t2");
    repeat (6) @(negedge clk);
    check("t2_no_second_frame", cs[0], 1);

    // 3: reset during TX bit 7 aborts cleanly
    send(0, 16'hFF00, 16'h1111, 1'b0);
    n = 0;
    while (g_side[0].rise_n < 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (g_side[0].rise_n < 8) fail_now("t3_reach_bit7");
    rst[0] = 1'b1;
    @(negedge clk);
    check("t3_cs", cs[0], 1);
    check("t3_sck", sck[0], 0);
    check("t3_busy", busy[0], 0);
    check("t3_done", done[0], 0);
    check("t3_rx_cleared", rxd[0], 0);
    rst[0] = 1'b0;
    @(negedge clk);
    send(0, 16'h0F0F, 16'hF0F0, 1'b1);
    wait_done(0, 400, "t3");
    wait_idle(0, 20, "t3");

    // 4: back-to-back frames with start held high
    resp_q[0].push_back(16'h7FFE);
    resp_q[0].push_back(16'hAAAA);
    sb_q[0].push_back(exp_t'{16'h8001, 16'h7FFE, 142});
    sb_q[0].push_back(exp_t'{16'h5555, 16'hAAAA, 142});
    start[0] = 1'b1;
    tx_d[0]  = 16'h8001;
    @(negedge clk);
    tx_d[0] = 16'h5555;
    wait_done(0, 400, "t4a");
    gap = 0;
    n   = 0;
    while (cs[0] === 1'b1 && n < 20) begin
      gap++;
      @(negedge clk);
      n++;
    end
    check("t4_cs_gap_ge2", (gap >= 2), 1);
    @(negedge clk);
    wait_done(0, 400, "t4b");
    start[0] = 1'b0;
    wait_idle(0, 20, "t4");

    // 5: CLK_DIV=1, PAUSE=0 side
    send(1, 16'hC3A5, 16'h5A3C, 1'b1);
    wait_done(1, 200, "t5a");
    wait_idle(1, 20, "t5a");
    send(1, 16'h0001, 16'h8000, 1'b1);
    wait_done(1, 200, "t5b");
    wait_idle(1, 20, "t5b");

    repeat (4) @(negedge clk);
    check("copi_stable_a", g_side[0].viol_copi, 0);
    check("sck_idle_a", g_side[0].viol_idle, 0);
    check("done_pulse_a", g_side[0].viol_done, 0);
    check("copi_stable_b", g_side[1].viol_copi, 0);
    check("sck_idle_b", g_side[1].viol_idle, 0);
    check("done_pulse_b", g_side[1].viol_done, 0);
    check("sb_empty_a", sb_q[0].size(), 0);
    check("sb_empty_b", sb_q[1].size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
